// File: rtl/blit_pkg.sv
// blit_pkg: shared state encoding, logic-function constants and per-bit LFU helper
package blit_pkg;
    typedef enum logic [2:0] {IDLE, RDREQ, LATCH, MODIFY, WRREQ, FIN} state_t;
    localparam logic [3:0] LFU_ZERO = 4'h0;
    localparam logic [3:0] LFU_XOR  = 4'h6;
    localparam logic [3:0] LFU_DST  = 4'hA;
    localparam logic [3:0] LFU_SRC  = 4'hC;
    localparam logic [3:0] LFU_ONES = 4'hF;
    function automatic logic lfu_bit(input logic [3:0] f, input logic s, input logic d);
        return f[{s, d}];
    endfunction
endpackage

// File: rtl/blit_dst_rmw_if.sv
// blit_dst_rmw_if: control, memory and data-path signals of the destination read-modify-write block
interface blit_dst_rmw_if;
    logic       START;
    logic       DSTUP;
    logic [3:0] LFU;
    logic [7:0] SRCD;
    logic       INHIB;
    logic       MACK;
    logic [7:0] ID;
    logic [7:0] DSTD;
    logic       LDDSTL;
    logic       MREQ;
    logic       MWR;
    logic [7:0] WD;
    logic       BUSY;
    logic       DONE;
    modport slave (
        input  START, DSTUP, LFU, SRCD, INHIB, MACK, ID, DSTD,
        output LDDSTL, MREQ, MWR, WD, BUSY, DONE
    );
    modport master (
        output START, DSTUP, LFU, SRCD, INHIB, MACK, ID, DSTD,
        input  LDDSTL, MREQ, MWR, WD, BUSY, DONE
    );
endinterface

// File: rtl/blit_lfu.sv
// blit_lfu: per-bit 4-entry truth-table logic function of source and destination bytes
import blit_pkg::*;
module blit_lfu (
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [3:0] lfu,
    output logic [7:0] res
);
    always_comb begin
        res = 8'h00;
        for (int i = 0; i < 8; i++) res[i] = lfu_bit(lfu, src[i], dst[i]);
    end
endmodule

// File: rtl/blit_dst_rmw.sv
// blit_dst_rmw: optional destination read, logic-function modify and inhibitable write-back of one byte
import blit_pkg::*;
module blit_dst_rmw (
    input logic MasterClock,
    input logic RESETL,
    blit_dst_rmw_if.slave bus
);
    state_t     state;
    logic       dst_up;
    logic [7:0] lfu_res;
    blit_lfu u_lfu (
        .src(bus.SRCD),
        .dst(dst_up ? bus.DSTD : 8'h00),
        .lfu(bus.LFU),
        .res(lfu_res)
    );
    // strobe only in the acknowledged read cycle so the register captures live ID
    assign bus.LDDSTL = !(state == RDREQ && bus.MACK);
    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            state    <= IDLE;
            dst_up   <= 1'b0;
            bus.MREQ <= 1'b0;
            bus.MWR  <= 1'b0;
            bus.WD   <= 8'h00;
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: if (bus.START) begin
                    dst_up   <= bus.DSTUP;
                    state    <= bus.DSTUP ? RDREQ : MODIFY;
                    bus.MREQ <= bus.DSTUP;
                    bus.MWR  <= 1'b0;
                    bus.BUSY <= 1'b1;
                end
                RDREQ: if (bus.MACK) begin
                    state    <= LATCH;
                    bus.MREQ <= 1'b0;
                end
                LATCH: state <= MODIFY;
                MODIFY: begin
                    bus.WD   <= lfu_res;
                    state    <= bus.INHIB ? FIN : WRREQ;
                    bus.MREQ <= !bus.INHIB;
                    bus.MWR  <= !bus.INHIB;
                    bus.DONE <= bus.INHIB;
                end
                WRREQ: if (bus.MACK) begin
                    state    <= FIN;
                    bus.MREQ <= 1'b0;
                    bus.MWR  <= 1'b0;
                    bus.DONE <= 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    bus.BUSY <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.MREQ <= 1'b0;
                    bus.MWR  <= 1'b0;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule
